// File: rtl/rv_dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: size encodings,
// FSM states and the lane-select / extension helpers.
package rv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } lsu_state_e;

  // Unknown sizes count as faults so a stray funct3 can never touch memory.
  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] off);
    logic fault;
    case (f3)
      F3_B, F3_BU: fault = 1'b0;
      F3_H, F3_HU: fault = off[0];
      F3_W:        fault = (off != 2'b00);
      default:     fault = 1'b1;
    endcase
    return fault;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicating the store data lets the byte enables pick the right lane.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (f3)
      F3_B:    lanes = {4{wdata[7:0]}};
      F3_H:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] result;
    byteSel = word[{off, 3'b000} +: 8];
    halfSel = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    result = {{24{byteSel[7]}}, byteSel};
      F3_BU:   result = {24'h000000, byteSel};
      F3_H:    result = {{16{halfSel[15]}}, halfSel};
      F3_HU:   result = {16'h0000, halfSel};
      F3_W:    result = word;
      default: result = 32'h0000_0000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rv_dmem_lsu_if.sv
// Memory-stage request/response bundle plus the registered MMIO store port.
interface rv_dmem_lsu_if;

  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        access_err;
  logic        mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  rdata, stall, access_err, mmio_we, mmio_addr, mmio_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output rdata, stall, access_err, mmio_we, mmio_addr, mmio_wdata
  );

endinterface

// File: rtl/rv_dmem_lsu_ram.sv
// Word-organised data array: byte-enable synchronous write, asynchronous read.
// Contents are deliberately not reset so a core reset keeps program data.
module dmem_ram #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we && i_be[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/rv_dmem_lsu.sv
// Load/store unit in front of the data RAM: size handling, fault detection,
// optional multi-cycle read with pipeline stall, and a registered MMIO store port.
module rv_dmem_lsu
  import rv_lsu_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          RD_LATENCY  = 0,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input logic          clk,
  input logic          rst,
  rv_dmem_lsu_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]  w_off;
  logic        w_err;
  logic        w_isMmio;
  logic        w_reqOk;
  logic        w_ramStore;
  logic        w_ramLoad;
  logic        w_mmioStore;
  logic [31:0] w_ramWord;
  logic [31:0] w_loadData;

  logic        r_mmioWe;
  logic [31:0] r_mmioAddr;
  logic [31:0] r_mmioWdata;

  assign w_off       = bus.req_addr[1:0];
  assign w_err       = bus.req_valid && access_fault(bus.req_funct3, w_off);
  assign w_isMmio    = (bus.req_addr >= MMIO_BASE);
  assign w_reqOk     = bus.req_valid && !w_err;
  assign w_ramStore  = w_reqOk &&  bus.req_we && !w_isMmio;
  assign w_ramLoad   = w_reqOk && !bus.req_we && !w_isMmio;
  assign w_mmioStore = w_reqOk &&  bus.req_we &&  w_isMmio;

  assign bus.access_err = w_err;

  // Addresses above the array depth simply wrap onto the low words.
  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .i_addr (bus.req_addr[AW+1:2]),
    .i_we   (w_ramStore),
    .i_be   (store_be(bus.req_funct3, w_off)),
    .i_wdata(store_lanes(bus.req_funct3, bus.req_wdata)),
    .o_rdata(w_ramWord)
  );

  assign w_loadData = load_extend(w_ramWord, w_off, bus.req_funct3);

  // MMIO stores always forward the full word; the peripheral decodes the size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mmioWe    <= 1'b0;
      r_mmioAddr  <= 32'h0000_0000;
      r_mmioWdata <= 32'h0000_0000;
    end else begin
      r_mmioWe <= w_mmioStore;
      if (w_mmioStore) begin
        r_mmioAddr  <= bus.req_addr;
        r_mmioWdata <= bus.req_wdata;
      end
    end
  end

  assign bus.mmio_we    = r_mmioWe;
  assign bus.mmio_addr  = r_mmioAddr;
  assign bus.mmio_wdata = r_mmioWdata;

  if (RD_LATENCY == 0) begin : g_comb
    assign bus.rdata = w_ramLoad ? w_loadData : 32'h0000_0000;
    assign bus.stall = 1'b0;
  end else begin : g_fsm
    lsu_state_e  r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_rdata;

    // The request is held stable while stalled, so the data sampled on the
    // last WAIT cycle is the one presented during DONE.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= IDLE;
        r_cnt   <= 3'd0;
        r_rdata <= 32'h0000_0000;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ramLoad) begin
              r_state <= WAIT;
              r_cnt   <= 3'(RD_LATENCY - 1);
            end
          end
          WAIT: begin
            if (r_cnt == 3'd0) begin
              r_state <= DONE;
              r_rdata <= w_loadData;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end

    assign bus.rdata = (r_state == DONE) ? r_rdata : 32'h0000_0000;
    assign bus.stall = ((r_state == IDLE) && w_ramLoad) || (r_state == WAIT);

    a_reqStableInWait: assert property (@(posedge clk) disable iff (rst)
      (r_state == WAIT) |-> ($stable(bus.req_valid) && $stable(bus.req_we) &&
                             $stable(bus.req_funct3) && $stable(bus.req_addr)));
  end

endmodule

// File: tb/tb_rv_dmem_lsu.sv
// Directed bench for rv_dmem_lsu: zero-latency, three-cycle-latency and
// shallow (wrapping) instances driven side by side from one sequence.
module tb_rv_dmem_lsu;
  import rv_lsu_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic sawStallNoLat;

  rv_dmem_lsu_if b0 ();
  rv_dmem_lsu_if b3 ();
  rv_dmem_lsu_if b16 ();

  rv_dmem_lsu #(.DEPTH_WORDS(64), .RD_LATENCY(0), .MMIO_BASE(32'h0000_1000)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  rv_dmem_lsu #(.DEPTH_WORDS(64), .RD_LATENCY(3), .MMIO_BASE(32'h0000_1000)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave));
  rv_dmem_lsu #(.DEPTH_WORDS(16), .RD_LATENCY(0), .MMIO_BASE(32'h0000_1000)) dut16 (
    .clk(clk), .rst(rst), .bus(b16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-latency instances must never stall, whatever the traffic.
  always @(negedge clk) begin
    if (b0.stall !== 1'b0 || b16.stall !== 1'b0) sawStallNoLat = 1'b1;
  end

  task automatic set0(input logic v, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
    b0.req_valid = v; b0.req_we = we; b0.req_funct3 = f3; b0.req_addr = a; b0.req_wdata = d;
  endtask

  task automatic set3(input logic v, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
    b3.req_valid = v; b3.req_we = we; b3.req_funct3 = f3; b3.req_addr = a; b3.req_wdata = d;
  endtask

  task automatic set16(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    b16.req_valid = v; b16.req_we = we; b16.req_funct3 = f3; b16.req_addr = a; b16.req_wdata = d;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    total++; if (b0.mmio_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_mmio_we got=%b exp=0", b0.mmio_we); end
    total++; if (b0.mmio_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_mmio_addr got=%h exp=0", b0.mmio_addr); end
    total++; if (b0.mmio_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_mmio_wdata got=%h exp=0", b0.mmio_wdata); end
    total++; if (b3.stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall got=%b exp=0", b3.stall); end
    total++; if (b3.rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdata got=%h exp=0", b3.rdata); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_word;
    @(negedge clk); set0(1, 1, F3_W, 32'h10, 32'hDEADBEEF); #1;
    total++; if (b0.access_err !== 1'b0) begin bad++; $display("[TB] FAIL sw_err got=%b exp=0", b0.access_err); end
    @(negedge clk); set0(1, 0, F3_W, 32'h10, 32'h0); #1;
    total++; if (b0.rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL lw_word got=%h exp=deadbeef", b0.rdata); end
  endtask

  task automatic test_subword;
    @(negedge clk); set0(1, 1, F3_W, 32'h10, 32'h11223344);
    @(negedge clk); set0(1, 1, F3_B, 32'h13, 32'hABCDEF80);
    @(negedge clk); set0(1, 0, F3_W, 32'h10, 32'h0); #1;
    total++; if (b0.rdata !== 32'h80223344) begin bad++; $display("[TB] FAIL lw_after_sb got=%h exp=80223344", b0.rdata); end
    @(negedge clk); set0(1, 0, F3_B, 32'h13, 32'h0); #1;
    total++; if (b0.rdata !== 32'hFFFFFF80) begin bad++; $display("[TB] FAIL lb_neg got=%h exp=ffffff80", b0.rdata); end
    @(negedge clk); set0(1, 0, F3_BU, 32'h13, 32'h0); #1;
    total++; if (b0.rdata !== 32'h00000080) begin bad++; $display("[TB] FAIL lbu got=%h exp=00000080", b0.rdata); end
    @(negedge clk); set0(1, 0, F3_H, 32'h12, 32'h0); #1;
    total++; if (b0.rdata !== 32'hFFFF8022) begin bad++; $display("[TB] FAIL lh_hi got=%h exp=ffff8022", b0.rdata); end
    total++; if (b0.access_err !== 1'b0) begin bad++; $display("[TB] FAIL lh_aligned_err got=%b exp=0", b0.access_err); end
    @(negedge clk); set0(1, 0, F3_HU, 32'h12, 32'h0); #1;
    total++; if (b0.rdata !== 32'h00008022) begin bad++; $display("[TB] FAIL lhu got=%h exp=00008022", b0.rdata); end
    @(negedge clk); set0(1, 0, F3_B, 32'h10, 32'h0); #1;
    total++; if (b0.rdata !== 32'h00000044) begin bad++; $display("[TB] FAIL lb_pos got=%h exp=00000044", b0.rdata); end
    @(negedge clk); set0(1, 1, F3_W, 32'h14, 32'h0);
    @(negedge clk); set0(1, 1, F3_H, 32'h16, 32'hAAAA7766);
    @(negedge clk); set0(1, 1, F3_H, 32'h14, 32'h0000BEEF);
    @(negedge clk); set0(1, 0, F3_W, 32'h14, 32'h0); #1;
    total++; if (b0.rdata !== 32'h7766BEEF) begin bad++; $display("[TB] FAIL lw_after_sh got=%h exp=7766beef", b0.rdata); end
    @(negedge clk); set0(1, 0, F3_H, 32'h14, 32'h0); #1;
    total++; if (b0.rdata !== 32'hFFFFBEEF) begin bad++; $display("[TB] FAIL lh_lo got=%h exp=ffffbeef", b0.rdata); end
  endtask

  task automatic test_errors;
    @(negedge clk); set0(1, 1, F3_W, 32'h00, 32'hCAFEF00D);
    @(negedge clk); set0(1, 0, F3_W, 32'h02, 32'h0); #1;
    total++; if (b0.access_err !== 1'b1) begin bad++; $display("[TB] FAIL lw_mis_err got=%b exp=1", b0.access_err); end
    total++; if (b0.rdata !== 32'h0) begin bad++; $display("[TB] FAIL lw_mis_rdata got=%h exp=0", b0.rdata); end
    @(negedge clk); set0(1, 1, F3_H, 32'h01, 32'h00001234); #1;
    total++; if (b0.access_err !== 1'b1) begin bad++; $display("[TB] FAIL sh_mis_err got=%b exp=1", b0.access_err); end
    @(negedge clk); set0(1, 1, F3_W, 32'h03, 32'h99999999);
    @(negedge clk); set0(1, 1, 3'b011, 32'h00, 32'h55555555); #1;
    total++; if (b0.access_err !== 1'b1) begin bad++; $display("[TB] FAIL f3_011_err got=%b exp=1", b0.access_err); end
    @(negedge clk); set0(1, 0, F3_W, 32'h00, 32'h0); #1;
    total++; if (b0.rdata !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL word_after_err got=%h exp=cafef00d", b0.rdata); end
    @(negedge clk); set0(1, 0, 3'b111, 32'h00, 32'h0); #1;
    total++; if (b0.access_err !== 1'b1) begin bad++; $display("[TB] FAIL f3_111_err got=%b exp=1", b0.access_err); end
    total++; if (b0.rdata !== 32'h0) begin bad++; $display("[TB] FAIL f3_111_rdata got=%h exp=0", b0.rdata); end
    @(negedge clk); set0(1, 0, 3'b110, 32'h00, 32'h0); #1;
    total++; if (b0.access_err !== 1'b1) begin bad++; $display("[TB] FAIL f3_110_err got=%b exp=1", b0.access_err); end
    @(negedge clk); set0(1, 0, F3_HU, 32'h03, 32'h0); #1;
    total++; if (b0.access_err !== 1'b1) begin bad++; $display("[TB] FAIL lhu_mis_err got=%b exp=1", b0.access_err); end
    @(negedge clk); set0(1, 0, F3_BU, 32'h03, 32'h0); #1;
    total++; if (b0.access_err !== 1'b0) begin bad++; $display("[TB] FAIL lbu_odd_err got=%b exp=0", b0.access_err); end
    total++; if (b0.rdata !== 32'h000000CA) begin bad++; $display("[TB] FAIL lbu_odd got=%h exp=000000ca", b0.rdata); end
  endtask

  task automatic test_mmio;
    @(negedge clk); set0(1, 1, F3_W, 32'h1000, 32'h00000055); #1;
    total++; if (b0.mmio_we !== 1'b0) begin bad++; $display("[TB] FAIL mmio_we_early got=%b exp=0", b0.mmio_we); end
    @(negedge clk); set0(1, 0, F3_W, 32'h1000, 32'h0); #1;
    total++; if (b0.mmio_we !== 1'b1) begin bad++; $display("[TB] FAIL mmio_we_pulse got=%b exp=1", b0.mmio_we); end
    total++; if (b0.mmio_addr !== 32'h1000) begin bad++; $display("[TB] FAIL mmio_addr got=%h exp=00001000", b0.mmio_addr); end
    total++; if (b0.mmio_wdata !== 32'h55) begin bad++; $display("[TB] FAIL mmio_wdata got=%h exp=00000055", b0.mmio_wdata); end
    total++; if (b0.rdata !== 32'h0) begin bad++; $display("[TB] FAIL mmio_load got=%h exp=0", b0.rdata); end
    @(negedge clk); set0(1, 1, F3_B, 32'h1003, 32'hAABBCC77); #1;
    total++; if (b0.mmio_we !== 1'b0) begin bad++; $display("[TB] FAIL mmio_we_drop got=%b exp=0", b0.mmio_we); end
    total++; if (b0.mmio_addr !== 32'h1000) begin bad++; $display("[TB] FAIL mmio_addr_hold got=%h exp=00001000", b0.mmio_addr); end
    @(negedge clk); set0(1, 1, F3_W, 32'h1004, 32'h01020304); #1;
    total++; if (b0.mmio_wdata !== 32'hAABBCC77) begin bad++; $display("[TB] FAIL mmio_sb_full got=%h exp=aabbcc77", b0.mmio_wdata); end
    @(negedge clk); set0(1, 1, F3_W, 32'h0FFC, 32'h00000777); #1;
    total++; if (b0.mmio_we !== 1'b1) begin bad++; $display("[TB] FAIL mmio_b2b_we got=%b exp=1", b0.mmio_we); end
    total++; if (b0.mmio_addr !== 32'h1004) begin bad++; $display("[TB] FAIL mmio_b2b_addr got=%h exp=00001004", b0.mmio_addr); end
    @(negedge clk); set0(1, 0, F3_W, 32'h0FFC, 32'h0); #1;
    total++; if (b0.mmio_we !== 1'b0) begin bad++; $display("[TB] FAIL below_base_we got=%b exp=0", b0.mmio_we); end
    total++; if (b0.rdata !== 32'h777) begin bad++; $display("[TB] FAIL below_base_ram got=%h exp=00000777", b0.rdata); end
    @(negedge clk); set0(1, 0, F3_W, 32'h00, 32'h0); #1;
    total++; if (b0.rdata !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL mmio_no_ram got=%h exp=cafef00d", b0.rdata); end
    @(negedge clk); set0(1, 1, F3_H, 32'h1001, 32'h1234);
    @(negedge clk); set0(0, 0, F3_W, 32'h0, 32'h0); #1;
    total++; if (b0.mmio_we !== 1'b0) begin bad++; $display("[TB] FAIL mmio_err_we got=%b exp=0", b0.mmio_we); end
  endtask

  // One load on the RD_LATENCY=3 instance: four stall cycles, data on the fifth.
  task automatic test_latency_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk); set3(1, 0, f3, a, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k < 4) begin
        total++; if (b3.stall !== 1'b1) begin bad++; $display("[TB] FAIL lat_stall_c%0d addr=%h got=%b exp=1", k, a, b3.stall); end
      end else begin
        total++; if (b3.stall !== 1'b0) begin bad++; $display("[TB] FAIL lat_done_stall addr=%h got=%b exp=0", a, b3.stall); end
        total++; if (b3.rdata !== exp) begin bad++; $display("[TB] FAIL lat_data addr=%h got=%h exp=%h", a, b3.rdata, exp); end
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); set3(1, 1, F3_W, 32'h20, 32'h12345678); #1;
    total++; if (b3.stall !== 1'b0) begin bad++; $display("[TB] FAIL lat_store_stall got=%b exp=0", b3.stall); end
    test_latency_load(F3_W, 32'h20, 32'h12345678);
    test_latency_load(F3_B, 32'h23, 32'h00000012);
    test_latency_load(F3_H, 32'h22, 32'h00001234);
    @(negedge clk); set3(1, 1, F3_B, 32'h21, 32'h0000009A);
    test_latency_load(F3_B, 32'h21, 32'hFFFFFF9A);
    @(negedge clk); set3(0, 0, F3_W, 32'h0, 32'h0); #1;
    total++; if (b3.rdata !== 32'h0) begin bad++; $display("[TB] FAIL lat_idle_rdata got=%h exp=0", b3.rdata); end
    @(negedge clk); set3(1, 0, F3_W, 32'h22, 32'h0); #1;
    total++; if (b3.stall !== 1'b0) begin bad++; $display("[TB] FAIL lat_err_stall got=%b exp=0", b3.stall); end
    total++; if (b3.access_err !== 1'b1) begin bad++; $display("[TB] FAIL lat_err got=%b exp=1", b3.access_err); end
    @(negedge clk); set3(1, 0, F3_W, 32'h1000, 32'h0); #1;
    total++; if (b3.stall !== 1'b0) begin bad++; $display("[TB] FAIL lat_mmio_stall got=%b exp=0", b3.stall); end
    @(negedge clk); set3(0, 0, F3_W, 32'h0, 32'h0);
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk); set3(1, 0, F3_W, 32'h20, 32'h0); #1;
    total++; if (b3.stall !== 1'b1) begin bad++; $display("[TB] FAIL rw_stall_idle got=%b exp=1", b3.stall); end
    @(negedge clk); #1;
    total++; if (b3.stall !== 1'b1) begin bad++; $display("[TB] FAIL rw_stall_wait1 got=%b exp=1", b3.stall); end
    @(negedge clk); rst = 1'b1; set3(0, 0, F3_W, 32'h0, 32'h0); #1;
    total++; if (b3.stall !== 1'b0) begin bad++; $display("[TB] FAIL rw_stall_reset got=%b exp=0", b3.stall); end
    total++; if (b0.mmio_addr !== 32'h0) begin bad++; $display("[TB] FAIL rw_mmio_addr got=%h exp=0", b0.mmio_addr); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (b3.stall !== 1'b0) begin bad++; $display("[TB] FAIL rw_stall_after got=%b exp=0", b3.stall); end
    test_latency_load(F3_W, 32'h20, 32'h12349A78);
    @(negedge clk); set3(0, 0, F3_W, 32'h0, 32'h0);
    @(negedge clk); set0(1, 0, F3_W, 32'h00, 32'h0); #1;
    total++; if (b0.rdata !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL rw_ram_kept got=%h exp=cafef00d", b0.rdata); end
  endtask

  task automatic test_wrap;
    @(negedge clk); set16(1, 1, F3_W, 32'h40, 32'h000000A5);
    @(negedge clk); set16(1, 0, F3_W, 32'h00, 32'h0); #1;
    total++; if (b16.rdata !== 32'hA5) begin bad++; $display("[TB] FAIL wrap_lo got=%h exp=000000a5", b16.rdata); end
    @(negedge clk); set16(1, 1, F3_W, 32'h04, 32'h0000005A);
    @(negedge clk); set16(1, 0, F3_W, 32'h44, 32'h0); #1;
    total++; if (b16.rdata !== 32'h5A) begin bad++; $display("[TB] FAIL wrap_hi got=%h exp=0000005a", b16.rdata); end
    @(negedge clk); set16(0, 0, F3_W, 32'h0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    sawStallNoLat = 1'b0;
    rst = 1'b1;
    set0(0, 0, F3_W, 32'h0, 32'h0);
    set3(0, 0, F3_W, 32'h0, 32'h0);
    set16(0, 0, F3_W, 32'h0, 32'h0);

    test_reset;
    test_word;
    test_subword;
    test_errors;
    test_mmio;
    test_back_to_back;
    test_reset_in_wait;
    test_wrap;

    @(negedge clk);
    total++; if (sawStallNoLat !== 1'b0) begin bad++; $display("[TB] FAIL no_lat_stall got=%b exp=0", sawStallNoLat); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_dmem_lsu.md
# rv_dmem_lsu

Parametrised load/store unit plus data memory for the five-stage pipelined core, replacing the fixed word-only data memory at SoC top level. It sits between the Memory stage and the data array and adds byte/halfword access with sign/zero extension, misalignment and illegal-size detection, configurable read latency with a pipeline stall, and a registered memory-mapped store port for off-core peripherals. With `RD_LATENCY=0` it behaves as an asynchronous-read, synchronous-write word memory, so existing word-only programs are unaffected.

## Interface
- `DEPTH_WORDS`, default 64: RAM depth in 32-bit words; must be a power of 2, ≥4.
- `RD_LATENCY`, default 0: extra cycles for a RAM load; range 0..7.
- `MMIO_BASE`, default 32'h0000_1000: addresses ≥ this value go to the MMIO port, not the RAM.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: Memory stage holds a load or store.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V size encoding: B=000, H=001, W=010, BU=100, HU=101.
- `req_addr` in 32: byte address (ALUResultM).
- `req_wdata` in 32: store data (WriteDataM), right-aligned.
- `rdata` out 32: extended load result.
- `stall` out 1: freeze IF..M and keep the request stable.
- `access_err` out 1: misaligned access or illegal funct3. Combinational.
- `mmio_we` out 1: one-cycle registered store strobe.
- `mmio_addr` out 32: registered MMIO store address.
- `mmio_wdata` out 32: registered MMIO store data.

## Operation
- Index = `req_addr[AW+1:2]`, AW = log2(DEPTH_WORDS). RAM addresses beyond the depth wrap.
- Errors:
  - `access_err`=1 for funct3 ∈ {011,110,111}.
  - `access_err`=1 for H/HU with addr[0]=1.
  - `access_err`=1 for W with addr[1:0]≠0.
  - An erroring request performs no write, no MMIO strobe and no stall; `rdata`=0.
- Stores, always single-cycle, no stall:
  - SB writes the lane selected by addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0}/{addr[1],1} with wdata[15:0].
  - SW writes all 4 lanes.
  - Other lanes are unchanged.
- MMIO store: on the next edge, `mmio_we`=1 and `mmio_addr`/`mmio_wdata` are latched, with the full 32-bit wdata regardless of size. `mmio_we` drops the following cycle unless another MMIO store follows.
- MMIO load: returns 0, no stall.
- Load extension:
  - B/H sign-extend the selected byte/half.
  - BU/HU zero-extend.
  - W passes through.
- FSM when `RD_LATENCY>0`:
  - IDLE → WAIT on a valid, error-free RAM load; counter loads RD_LATENCY-1.
  - WAIT decrements the counter; at 0 → DONE.
  - DONE drives the registered extended data on `rdata`, with `stall`=0, for one cycle → IDLE.
  - `stall` = valid RAM load in IDLE, or state=WAIT.
- FSM when `RD_LATENCY=0`: the FSM is unused; `rdata` is combinational from the array; `stall`=0 always.
- Back-to-back loads: DONE always returns to IDLE, so the next load restarts the sequence.
- Reset mid-WAIT: returns to IDLE with `stall`=0; RAM contents are retained (not reset).
- Reset values: `stall`=0, `mmio_we`=0, `mmio_addr`=0, `mmio_wdata`=0, `rdata`=0 in the registered path; FSM=IDLE; counter=0.

## Timing
- RAM and MMIO writes commit on the rising edge of the cycle in which the request is presented.
- Read-after-write to the same word in the next cycle returns the new data.
- Load accepted in cycle t:
  - `stall` is high in cycles t..t+RD_LATENCY.
  - `rdata` is valid and `stall` low in cycle t+RD_LATENCY+1; the pipeline captures at the end of that cycle.
  - Total visible stall = RD_LATENCY+1 cycles.
- `access_err` is combinational, same cycle as the request.
- `req_*` must remain stable while `stall`=1. Changes during WAIT are undefined and are covered by an assertion.

## Structure
- Package `rv_lsu_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state typedef (IDLE, WAIT, DONE).
  - Lane-select/extension helper function.
- Sub-module `dmem_ram`: DEPTH_WORDS × 32 array with a 4-bit byte-enable synchronous write and an asynchronous read. It is the only storage; the FSM, error logic and MMIO registers live in `rv_dmem_lsu`.

## Test plan
- RD_LATENCY=0: SW 0xDEADBEEF @0x10, then LW @0x10 → `rdata`=0xDEADBEEF same cycle, `stall` never high.
- SB 0x80 @0x13 over 0x11223344 → LW=0x80223344; LB @0x13 → 0xFFFFFF80; LBU → 0x00000080; LH @0x12 → 0xFFFF8022.
- LW @0x02 and SH @0x01 → `access_err`=1, word unchanged, no `stall`; funct3=111 → `access_err`=1.
- RD_LATENCY=3: LW @0x20 → `stall` high 4 cycles, data in 5th; assert `reset` in 2nd WAIT cycle → `stall`=0 next cycle, FSM=IDLE, memory intact.
- SW 0x55 @0x1000, then LW @0x1000 → `mmio_we` pulse 1 cycle after the store with addr 0x1000 / data 0x55; load returns 0.
- DEPTH_WORDS=16: SW 0xA5 @0x40 → LW @0x00 reads 0xA5 (wrap).
